// File: rtl/sound_sequencer.sv
// Sound-effect sequencer: accepts one-cycle play requests, arbitrates them by
// fixed priority and steps through a short note table, driving a square-wave
// speaker pin. All outputs are registered.
module sound_sequencer #(
  parameter int NOTE_TICKS    = 2_500_000,
  parameter int GAP_TICKS     = 250_000,
  parameter int TONE_PRESCALE = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play_req,
  input  logic [1:0] sound_sel,
  input  logic       mute,
  output logic       speaker,
  output logic       busy,
  output logic [1:0] active_sound,
  output logic [1:0] note_idx,
  output logic       done
);

  // One counter times both TONE and GAP, so it is sized for the longer one.
  localparam int DUR_MAX = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int DUR_W   = $clog2(DUR_MAX + 1);
  localparam int PRE_W   = $clog2(TONE_PRESCALE + 1);
  localparam int TONE_W  = 9;

  localparam logic [DUR_W-1:0] NOTE_LAST = DUR_W'(NOTE_TICKS - 1);
  localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TONE_PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [DUR_W-1:0]    dur_cnt, dur_n;
  logic [PRE_W-1:0]    pre_cnt, pre_n;
  logic [TONE_W-1:0]   tone_cnt, tone_n;
  logic                tone_ph, ph_n;
  logic [1:0]          active_n, idx_n;
  logic                done_n, busy_n, speaker_n;
  logic                tone_end, gap_end, is_last, seq_end, accept;
  logic [TONE_W-1:0]   half;

  // Half-period, in tone ticks, of note idx of sound snd.
  function automatic logic [TONE_W-1:0] half_period(input logic [1:0] snd,
                                                    input logic [1:0] idx);
    logic [TONE_W-1:0] hp;
    hp = 9'd239;
    case (snd)
      2'd0: hp = 9'd119;                                   // UI_PRESS: C6
      2'd1: begin                                          // NEXTLEVEL: C5 E5 G5
        case (idx)
          2'd0:    hp = 9'd239;
          2'd1:    hp = 9'd190;
          default: hp = 9'd159;
        endcase
      end
      2'd2: begin                                          // CRASH: G5 E5 C5 C4
        case (idx)
          2'd0:    hp = 9'd159;
          2'd1:    hp = 9'd190;
          2'd2:    hp = 9'd239;
          default: hp = 9'd478;
        endcase
      end
      default: begin                                       // CELEBRATION: C5 E5 G5 C6
        case (idx)
          2'd0:    hp = 9'd239;
          2'd1:    hp = 9'd190;
          2'd2:    hp = 9'd159;
          default: hp = 9'd119;
        endcase
      end
    endcase
    return hp;
  endfunction

  // Index of the final note of each sound.
  function automatic logic [1:0] last_note(input logic [1:0] snd);
    logic [1:0] ln;
    case (snd)
      2'd0:    ln = 2'd0;
      2'd1:    ln = 2'd2;
      default: ln = 2'd3;
    endcase
    return ln;
  endfunction

  // Arbitration rank: CRASH > CELEBRATION > NEXTLEVEL > UI_PRESS.
  function automatic logic [1:0] prio(input logic [1:0] snd);
    logic [1:0] p;
    case (snd)
      2'd0:    p = 2'd0;
      2'd1:    p = 2'd1;
      2'd2:    p = 2'd3;
      default: p = 2'd2;
    endcase
    return p;
  endfunction

  // Next-state, counter and output logic.
  always_comb begin
    state_n  = state;
    dur_n    = dur_cnt;
    pre_n    = pre_cnt;
    tone_n   = tone_cnt;
    ph_n     = tone_ph;
    active_n = active_sound;
    idx_n    = note_idx;
    done_n   = 1'b0;

    half     = half_period(active_sound, note_idx);
    tone_end = (state == TONE) && (dur_cnt == NOTE_LAST);
    gap_end  = (state == GAP) && (dur_cnt == GAP_LAST);
    is_last  = (note_idx == last_note(active_sound));
    seq_end  = ((GAP_TICKS == 0) ? tone_end : gap_end) && is_last;
    // A request at the natural end edge is taken regardless of rank.
    accept   = play_req && ((state == IDLE) || seq_end ||
                            (prio(sound_sel) >= prio(active_sound)));

    if (accept) begin
      state_n  = TONE;
      dur_n    = '0;
      pre_n    = '0;
      tone_n   = '0;
      ph_n     = 1'b0;
      active_n = sound_sel;
      idx_n    = 2'd0;
    end else begin
      case (state)
        TONE: begin
          if (tone_end) begin
            dur_n  = '0;
            pre_n  = '0;
            tone_n = '0;
            ph_n   = 1'b0;
            if (GAP_TICKS > 0) begin
              state_n = GAP;
            end else if (is_last) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              idx_n = note_idx + 2'd1;
            end
          end else begin
            dur_n = dur_cnt + DUR_W'(1);
            if (pre_cnt == PRE_LAST) begin
              pre_n = '0;
              if (tone_cnt == half - TONE_W'(1)) begin
                tone_n = '0;
                ph_n   = ~tone_ph;
              end else begin
                tone_n = tone_cnt + TONE_W'(1);
              end
            end else begin
              pre_n = pre_cnt + PRE_W'(1);
            end
          end
        end
        GAP: begin
          if (gap_end) begin
            dur_n = '0;
            if (is_last) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              state_n = TONE;
              idx_n   = note_idx + 2'd1;
            end
          end else begin
            dur_n = dur_cnt + DUR_W'(1);
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end

    busy_n    = (state_n != IDLE);
    // Mute only gates the pin; the tone phase keeps running underneath.
    speaker_n = (state_n == TONE) && ph_n && !mute;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      dur_cnt      <= '0;
      pre_cnt      <= '0;
      tone_cnt     <= '0;
      tone_ph      <= 1'b0;
      active_sound <= 2'd0;
      note_idx     <= 2'd0;
      done         <= 1'b0;
      busy         <= 1'b0;
      speaker      <= 1'b0;
    end else begin
      state        <= state_n;
      dur_cnt      <= dur_n;
      pre_cnt      <= pre_n;
      tone_cnt     <= tone_n;
      tone_ph      <= ph_n;
      active_sound <= active_n;
      note_idx     <= idx_n;
      done         <= done_n;
      busy         <= busy_n;
      speaker      <= speaker_n;
    end
  end

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer with short note/gap timing.
module tb_sound_sequencer;

  logic       clk;
  logic       reset;
  logic       play_req;
  logic [1:0] sound_sel;
  logic       mute;
  logic       speaker;
  logic       busy;
  logic [1:0] active_sound;
  logic [1:0] note_idx;
  logic       done;

  int n_tests;
  int n_fail;
  int note_start[4];
  int note_rise[4];
  int bcyc, tog, rise2;

  sound_sequencer #(
    .NOTE_TICKS   (1000),
    .GAP_TICKS    (8),
    .TONE_PRESCALE(1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .play_req    (play_req),
    .sound_sel   (sound_sel),
    .mute        (mute),
    .speaker     (speaker),
    .busy        (busy),
    .active_sound(active_sound),
    .note_idx    (note_idx),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [1:0] sel);
    play_req  = 1'b1;
    sound_sel = sel;
    step();
    play_req  = 1'b0;
  endtask

  // Called on the sample just after an accept; runs until busy drops.
  task automatic measure(input int limit, output int bc, output int tg, output int r2);
    logic       prev_spk;
    logic [1:0] prev_idx;
    bc = 0;
    tg = 0;
    r2 = -1;
    for (int k = 0; k < 4; k++) begin
      note_start[k] = -1;
      note_rise[k]  = -1;
    end
    note_start[note_idx] = 0;
    prev_spk = speaker;
    prev_idx = note_idx;
    while (busy && bc < limit) begin
      bc++;
      step();
      if (busy && note_idx != prev_idx) note_start[note_idx] = bc;
      if (speaker != prev_spk) begin
        tg++;
        if (speaker) begin
          if (note_rise[note_idx] < 0) note_rise[note_idx] = bc;
          else if (r2 < 0 && note_idx == 2'd0) r2 = bc;
        end
      end
      prev_spk = speaker;
      prev_idx = note_idx;
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    play_req  = 1'b1;
    sound_sel = 2'd3;
    mute      = 1'b0;

    // Reset held with a pending request
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_outs", {25'd0, speaker, busy, active_sound, note_idx, done}, 32'd0);
    end
    reset    = 1'b0;
    play_req = 1'b0;
    step();
    check("post_reset_outs", {25'd0, speaker, busy, active_sound, note_idx, done}, 32'd0);

    // UI_PRESS: one C6 note
    request(2'd0);
    check("ui_accept_busy", busy, 1);
    check("ui_accept_snd", active_sound, 0);
    check("ui_accept_idx", note_idx, 0);
    check("ui_accept_spk", speaker, 0);
    measure(3000, bcyc, tog, rise2);
    check("ui_busy_cycles", bcyc, 1008);
    check("ui_done", done, 1);
    check("ui_first_rise", note_rise[0], 119);
    check("ui_period", rise2 - note_rise[0], 238);
    check("ui_toggles", tog, 8);
    step();
    check("ui_done_once", done, 0);
    check("ui_idle_busy", busy, 0);

    // CELEBRATION: four notes
    request(2'd3);
    measure(6000, bcyc, tog, rise2);
    check("cel_busy_cycles", bcyc, 4032);
    check("cel_done", done, 1);
    check("cel_start1", note_start[1], 1008);
    check("cel_start2", note_start[2], 2016);
    check("cel_start3", note_start[3], 3024);
    check("cel_half0", note_rise[0] - note_start[0], 239);
    check("cel_half1", note_rise[1] - note_start[1], 190);
    check("cel_half2", note_rise[2] - note_start[2], 159);
    check("cel_half3", note_rise[3] - note_start[3], 119);
    step();

    // Priority during CELEBRATION
    request(2'd3);
    for (int i = 0; i < 2100; i++) step();
    check("prio_at_note2", note_idx, 2);
    request(2'd0);
    check("prio_ui_snd", active_sound, 3);
    check("prio_ui_idx", note_idx, 2);
    check("prio_ui_busy", busy, 1);
    request(2'd2);
    check("prio_crash_snd", active_sound, 2);
    check("prio_crash_idx", note_idx, 0);
    check("prio_crash_done", done, 0);
    check("prio_crash_busy", busy, 1);
    check("prio_crash_spk", speaker, 0);

    // Reset in the middle of CRASH while the speaker is high
    for (int i = 0; i < 200; i++) step();
    check("crash_spk_high", speaker, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_reset_outs", {25'd0, speaker, busy, active_sound, note_idx, done}, 32'd0);
    step();

    // Muted NEXTLEVEL
    mute = 1'b1;
    request(2'd1);
    measure(6000, bcyc, tog, rise2);
    check("mute_busy_cycles", bcyc, 3024);
    check("mute_done", done, 1);
    check("mute_toggles", tog, 0);
    mute = 1'b0;
    step();

    // Lower-rank request on the natural end edge of NEXTLEVEL
    request(2'd1);
    for (int i = 0; i < 3023; i++) step();
    check("end_last_busy", busy, 1);
    check("end_last_idx", note_idx, 2);
    request(2'd0);
    check("end_restart_busy", busy, 1);
    check("end_restart_done", done, 0);
    check("end_restart_snd", active_sound, 0);
    check("end_restart_idx", note_idx, 0);
    measure(3000, bcyc, tog, rise2);
    check("end_restart_cycles", bcyc, 1008);
    check("end_restart_fin", done, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
